// File: rtl/pong_pkg.sv
// Shared pong definitions: game-state encoding, field geometry, serve
// parameters and the common position/velocity width.
package pong_pkg;

  localparam int POS_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_SCORE = 2'd3
  } game_state_t;

  localparam logic [POS_W-1:0] CENTER_X     = 10'd320;
  localparam logic [POS_W-1:0] CENTER_Y     = 10'd240;
  localparam logic [POS_W-1:0] UP_Y         = 10'd140;
  localparam logic [POS_W-1:0] DOWN_Y       = 10'd340;
  localparam logic [POS_W-1:0] LEFT_GOAL_X  = 10'd130;
  localparam logic [POS_W-1:0] RIGHT_GOAL_X = 10'd510;
  localparam logic [POS_W-1:0] INIT_VX      = 10'd2;
  localparam logic [POS_W-1:0] INIT_VY      = 10'd1;
  localparam logic [POS_W-1:0] SPEED_CAP    = 10'd8;

  localparam int HOLD_STEPS = 60;
  localparam int HOLD_W     = $clog2(HOLD_STEPS);

  function automatic logic [POS_W-1:0] negate(input logic [POS_W-1:0] v);
    return ~v + 1'b1;
  endfunction

endpackage

// File: rtl/ball_integrator.sv
// Pure datapath: integrates one velocity step into the ball position,
// clamps y to the walls and flags/saturates goals on the new x.
module ball_integrator
  import pong_pkg::*;
(
  input  logic [POS_W-1:0] pos_x,
  input  logic [POS_W-1:0] pos_y,
  input  logic [POS_W-1:0] vel_x,
  input  logic [POS_W-1:0] vel_y,
  output logic [POS_W-1:0] new_x,
  output logic [POS_W-1:0] new_y,
  output logic             goal_left,
  output logic             goal_right
);

  logic [POS_W:0] sum_x;
  logic [POS_W:0] sum_y;

  // NOTE: every output gets a value on every path, so no latches are inferred.
  always_comb begin
    // 11-bit modular add of unsigned position and sign-extended velocity;
    // bit POS_W is the sign of the result.
    sum_x = {1'b0, pos_x} + {vel_x[POS_W-1], vel_x};
    sum_y = {1'b0, pos_y} + {vel_y[POS_W-1], vel_y};

    goal_left  = sum_x[POS_W] || (sum_x[POS_W-1:0] <= LEFT_GOAL_X);
    goal_right = !sum_x[POS_W] && (sum_x[POS_W-1:0] >= RIGHT_GOAL_X);

    if (goal_left)       new_x = LEFT_GOAL_X;
    else if (goal_right) new_x = RIGHT_GOAL_X;
    else                 new_x = sum_x[POS_W-1:0];

    if (sum_y[POS_W] || (sum_y[POS_W-1:0] < UP_Y)) new_y = UP_Y;
    else if (sum_y[POS_W-1:0] > DOWN_Y)             new_y = DOWN_Y;
    else                                            new_y = sum_y[POS_W-1:0];
  end

endmodule

// File: rtl/ball_motion.sv
// Registered ball-motion stage: serve/play/score sequencing, velocity latch,
// position integration and goal pulses. Optional BALL_SPEEDUP_EN adds rally speed-up.
module ball_motion
  import pong_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  input  logic             start,
  input  logic             game_over,
  input  logic [POS_W-1:0] next_speed_x,
  input  logic [POS_W-1:0] next_speed_y,
  output logic [POS_W-1:0] ball_x,
  output logic [POS_W-1:0] ball_y,
  output logic [POS_W-1:0] now_speed_x,
  output logic [POS_W-1:0] now_speed_y,
  output logic [1:0]       game_state,
  output logic             point_p1,
  output logic             point_p2
);

  game_state_t       state, state_next;
  logic [HOLD_W-1:0] hold_cnt, hold_next;
  logic              serve_neg;
  logic [POS_W-1:0]  new_x, new_y, latch_vx;
  logic              goal_left, goal_right;

  ball_integrator u_integrator (
    .pos_x      (ball_x),
    .pos_y      (ball_y),
    .vel_x      (next_speed_x),
    .vel_y      (next_speed_y),
    .new_x      (new_x),
    .new_y      (new_y),
    .goal_left  (goal_left),
    .goal_right (goal_right)
  );

  assign game_state = state;

  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    unique case (state)
      ST_IDLE:  if (start) state_next = ST_SERVE;
      ST_SERVE: state_next = ST_PLAY;
      ST_PLAY:  if (step && (goal_left || goal_right)) state_next = ST_SCORE;
      ST_SCORE: begin
        if (step) begin
          if (hold_cnt == HOLD_W'(HOLD_STEPS - 1)) begin
            hold_next  = '0;
            state_next = game_over ? ST_IDLE : ST_SERVE;
          end else begin
            hold_next = hold_cnt + 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_next;
      hold_cnt <= hold_next;
    end
  end

`ifdef BALL_SPEEDUP_EN
  logic [3:0]       rally_cnt, rally_inc;
  logic             flip, bump;
  logic [POS_W-1:0] mag, mag_adj;

  // A sign change of x velocity is a paddle hit; every 4th hit adds one
  // pixel/step of magnitude to the latched x velocity.
  always_comb begin
    flip      = next_speed_x[POS_W-1] != now_speed_x[POS_W-1];
    rally_inc = rally_cnt + 1'b1;
    bump      = flip && (rally_inc[1:0] == 2'd0);
    mag       = next_speed_x[POS_W-1] ? negate(next_speed_x) : next_speed_x;
    mag_adj   = (bump && (mag < SPEED_CAP)) ? mag + 1'b1 : mag;
    latch_vx  = next_speed_x[POS_W-1] ? negate(mag_adj) : mag_adj;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rally_cnt <= '0;
    end else if (state == ST_SERVE) begin
      rally_cnt <= '0;
    end else if (state == ST_PLAY && step && !goal_left && !goal_right && flip) begin
      rally_cnt <= rally_inc;
    end
  end
`else
  assign latch_vx = next_speed_x;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ball_x      <= CENTER_X;
      ball_y      <= CENTER_Y;
      now_speed_x <= '0;
      now_speed_y <= '0;
      point_p1    <= 1'b0;
      point_p2    <= 1'b0;
      serve_neg   <= 1'b0;
    end else begin
      point_p1 <= 1'b0;
      point_p2 <= 1'b0;
      unique case (state)
        ST_SERVE: begin
          ball_x      <= CENTER_X;
          ball_y      <= CENTER_Y;
          now_speed_x <= serve_neg ? negate(INIT_VX) : INIT_VX;
          now_speed_y <= INIT_VY;
        end
        ST_PLAY: begin
          if (step) begin
            ball_x <= new_x;
            ball_y <= new_y;
            if (goal_left || goal_right) begin
              now_speed_x <= '0;
              now_speed_y <= '0;
              point_p1    <= goal_right;
              point_p2    <= goal_left;
              // The next serve heads toward the player who just conceded.
              serve_neg   <= goal_left;
            end else begin
              now_speed_x <= latch_vx;
              now_speed_y <= next_speed_y;
            end
          end
        end
        ST_SCORE: begin
          if (state_next == ST_IDLE) begin
            ball_x <= CENTER_X;
            ball_y <= CENTER_Y;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_motion.sv
// Self-checking bench for ball_motion: an integer behavioural model checked
// every cycle, plus directed vectors with hand-computed literal expectations.
module tb_ball_motion;

  logic       clk = 1'b0;
  logic       reset;
  logic       step, start, game_over;
  logic [9:0] next_speed_x, next_speed_y;
  logic [9:0] ball_x, ball_y, now_speed_x, now_speed_y;
  logic [1:0] game_state;
  logic       point_p1, point_p2;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state in plain integers: signed velocities, state 0..3.
  int m_x = 320, m_y = 240, m_vx = 0, m_vy = 0, m_state = 0;
  int m_dir = 1, m_hold = 0, m_rally = 0;
  int m_p1 = 0, m_p2 = 0;

  ball_motion dut (
    .clk          (clk),
    .reset        (reset),
    .step         (step),
    .start        (start),
    .game_over    (game_over),
    .next_speed_x (next_speed_x),
    .next_speed_y (next_speed_y),
    .ball_x       (ball_x),
    .ball_y       (ball_y),
    .now_speed_x  (now_speed_x),
    .now_speed_y  (now_speed_y),
    .game_state   (game_state),
    .point_p1     (point_p1),
    .point_p2     (point_p2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic logic [31:0] f10(input int v);
    return 32'(v) & 32'h3FF;
  endfunction

  task automatic model_reset();
    m_x = 320; m_y = 240; m_vx = 0; m_vy = 0; m_state = 0;
    m_dir = 1; m_hold = 0; m_rally = 0; m_p1 = 0; m_p2 = 0;
  endtask

  task automatic model_clock();
    int nvx, nvy, nx, ny, mag;
    m_p1 = 0;
    m_p2 = 0;
    case (m_state)
      0: if (start) m_state = 1;
      1: begin
        m_x = 320; m_y = 240; m_vx = 2 * m_dir; m_vy = 1; m_rally = 0; m_state = 2;
      end
      2: if (step) begin
        nvx = int'($signed(next_speed_x));
        nvy = int'($signed(next_speed_y));
        nx  = m_x + nvx;
        ny  = m_y + nvy;
        if (ny < 140) ny = 140;
        if (ny > 340) ny = 340;
        m_y = ny;
        if (nx <= 130) begin
          m_p2 = 1; m_dir = -1; m_x = 130; m_vx = 0; m_vy = 0; m_state = 3; m_hold = 0;
        end else if (nx >= 510) begin
          m_p1 = 1; m_dir = 1; m_x = 510; m_vx = 0; m_vy = 0; m_state = 3; m_hold = 0;
        end else begin
`ifdef BALL_SPEEDUP_EN
          if ((nvx < 0) != (m_vx < 0)) begin
            m_rally = (m_rally + 1) % 16;
            if (m_rally % 4 == 0) begin
              mag = (nvx < 0) ? -nvx : nvx;
              if (mag < 8) mag++;
              nvx = (nvx < 0) ? -mag : mag;
            end
          end
`endif
          m_x = nx; m_vx = nvx; m_vy = nvy;
        end
      end
      3: if (step) begin
        m_hold++;
        if (m_hold == 60) begin
          m_hold = 0;
          if (game_over) begin
            m_state = 0; m_x = 320; m_y = 240;
          end else begin
            m_state = 1;
          end
        end
      end
      default: m_state = 0;
    endcase
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else       model_clock();
  end

  always @(negedge clk) begin
    check("cyc ball_x", 32'(ball_x), f10(m_x));
    check("cyc ball_y", 32'(ball_y), f10(m_y));
    check("cyc now_speed_x", 32'(now_speed_x), f10(m_vx));
    check("cyc now_speed_y", 32'(now_speed_y), f10(m_vy));
    check("cyc game_state", 32'(game_state), 32'(m_state));
    check("cyc point_p1", 32'(point_p1), 32'(m_p1));
    check("cyc point_p2", 32'(point_p2), 32'(m_p2));
  end

  task automatic tick();
    @(posedge clk);
    #1;
    step  = 1'b0;
    start = 1'b0;
  endtask

  task automatic do_step(input int vx, input int vy);
    next_speed_x = 10'(vx);
    next_speed_y = 10'(vy);
    step = 1'b1;
    tick();
  endtask

  task automatic hold_out(input logic go);
    game_over = go;
    for (int i = 0; i < 60; i++) begin
      do_step(0, 0);
      if (i % 9 == 4 && i != 59) tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp4, exp28;
    reset = 1'b1; step = 1'b0; start = 1'b0; game_over = 1'b0;
    next_speed_x = '0; next_speed_y = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst ball_x", 32'(ball_x), 32'd320);
    check("rst ball_y", 32'(ball_y), 32'd240);
    check("rst vx", 32'(now_speed_x), 32'd0);
    check("rst state", 32'(game_state), 32'd0);
    reset = 1'b0;

    // step alone in IDLE does nothing; start+step together serves.
    do_step(5, 5);
    check("idle step state", 32'(game_state), 32'd0);
    start = 1'b1;
    do_step(7, 7);
    check("serve state", 32'(game_state), 32'd1);
    tick();
    check("play state", 32'(game_state), 32'd2);
    check("serve vx", 32'(now_speed_x), 32'd2);
    check("serve vy", 32'(now_speed_y), 32'd1);
    do_step(2, 1);
    check("first step x", 32'(ball_x), 32'd322);
    check("first step y", 32'(ball_y), 32'd241);

    // Wall clamps.
    do_step(0, 98);
    check("y 339", 32'(ball_y), 32'd339);
    do_step(0, 3);
    check("clamp down", 32'(ball_y), 32'd340);
    do_step(0, -99);
    do_step(0, -99);
    check("y 142", 32'(ball_y), 32'd142);
    do_step(0, -5);
    check("clamp up", 32'(ball_y), 32'd140);

    start = 1'b1;
    tick();
    check("start ignored", 32'(game_state), 32'd2);

    // Right goal past the line.
    do_step(93, 0);
    do_step(93, 0);
    check("x 508", 32'(ball_x), 32'd508);
    do_step(3, 0);
    check("p1 pulse", 32'(point_p1), 32'd1);
    check("right sat x", 32'(ball_x), 32'd510);
    check("goal vx", 32'(now_speed_x), 32'd0);
    check("score state", 32'(game_state), 32'd3);
    tick();
    check("p1 one cycle", 32'(point_p1), 32'd0);
    hold_out(1'b0);
    check("reserve state", 32'(game_state), 32'd1);
    tick();
    check("reserve vx +2", 32'(now_speed_x), 32'd2);

    // Left goal exactly on the line.
    do_step(-190, 0);
    check("p2 exact", 32'(point_p2), 32'd1);
    check("left x", 32'(ball_x), 32'd130);
    hold_out(1'b0);
    tick();
    check("reserve vx -2", 32'(now_speed_x), 32'h3FE);

    // Left goal through 11-bit underflow, then game over returns to IDLE.
    do_step(-185, 0);
    check("x 135", 32'(ball_x), 32'd135);
    do_step(-200, 0);
    check("p2 underflow", 32'(point_p2), 32'd1);
    check("underflow x", 32'(ball_x), 32'd130);
    hold_out(1'b1);
    check("game over idle", 32'(game_state), 32'd0);
    check("idle centre x", 32'(ball_x), 32'd320);
    game_over = 1'b0;

    // New rally keeps the -x serve; then asynchronous reset mid-PLAY.
    start = 1'b1;
    tick();
    tick();
    check("rally vx -2", 32'(now_speed_x), 32'h3FE);
    do_step(80, -40);
    check("x 400", 32'(ball_x), 32'd400);
    check("y 200", 32'(ball_y), 32'd200);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("async rst x", 32'(ball_x), 32'd320);
    check("async rst y", 32'(ball_y), 32'd240);
    check("async rst vx", 32'(now_speed_x), 32'd0);
    check("async rst vy", 32'(now_speed_y), 32'd0);
    check("async rst state", 32'(game_state), 32'd0);
    check("async rst p1", 32'(point_p1), 32'd0);
    check("async rst p2", 32'(point_p2), 32'd0);
    #10 reset = 1'b0;

    // Paddle-hit flips with upstream reflecting the current x velocity.
`ifdef BALL_SPEEDUP_EN
    exp4 = 3; exp28 = 8;
`else
    exp4 = 2; exp28 = 2;
`endif
    start = 1'b1;
    tick();
    tick();
    check("speedup serve vx", 32'(now_speed_x), 32'd2);
    for (int i = 1; i <= 28; i++) begin
      do_step(-m_vx, 0);
      if (i == 4)  check("vx after 4 flips", 32'(now_speed_x), 32'(exp4));
      if (i == 28) check("vx after 28 flips", 32'(now_speed_x), 32'(exp28));
    end
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
